// File: rtl/ser_pkg.sv
// Shared definitions for the serializer and the downstream pattern detector.
package ser_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

  localparam int DEF_WIDTH = 8;

  // The detector matches this many serial bits; both stages agree on it here.
  localparam int PATTERN_WIDTH = 4;

endpackage

// File: rtl/word_serializer.sv
// Parallel word in over valid/ready, one bit per clock out on a serial line.
// A one-word hold register lets consecutive words stream with no idle gap.
module word_serializer
  import ser_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             last_bit
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  ser_state_t       state, state_d;
  logic             hold_full;
  logic [WIDTH-1:0] hold_data;
  logic [WIDTH-1:0] shreg, shreg_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic             xfer, last, hold_load, hold_drain;
  logic             shift_d, bit_d;

  assign in_ready = !hold_full && !reset;
  assign xfer     = in_valid && in_ready;
  assign last     = (state == SHIFT) && (cnt == CNT_LAST);

  // shreg always holds the bit currently on ser_out at its output end.
  always_comb begin
    state_d    = state;
    shreg_d    = shreg;
    cnt_d      = cnt;
    hold_load  = 1'b0;
    hold_drain = 1'b0;
    case (state)
      IDLE: begin
        if (xfer) begin
          shreg_d = in_data;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (last) begin
          if (hold_full) begin
            shreg_d    = hold_data;
            cnt_d      = '0;
            hold_drain = 1'b1;
          end else if (xfer) begin
            shreg_d = in_data;
            cnt_d   = '0;
          end else begin
            shreg_d = '0;
            cnt_d   = '0;
            state_d = IDLE;
          end
        end else begin
          shreg_d   = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
          cnt_d     = cnt + CW'(1);
          hold_load = xfer;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign shift_d = (state_d == SHIFT);
  assign bit_d   = MSB_FIRST ? shreg_d[WIDTH-1] : shreg_d[0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      shreg       <= '0;
      cnt         <= '0;
      ser_out     <= 1'b0;
      ser_valid   <= 1'b0;
      frame_start <= 1'b0;
      last_bit    <= 1'b0;
    end else begin
      state       <= state_d;
      shreg       <= shreg_d;
      cnt         <= cnt_d;
      ser_out     <= shift_d && bit_d;
      ser_valid   <= shift_d;
      frame_start <= shift_d && (cnt_d == '0);
      last_bit    <= shift_d && (cnt_d == CNT_LAST);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_full <= 1'b0;
      hold_data <= '0;
    end else if (hold_load) begin
      hold_full <= 1'b1;
      hold_data <= in_data;
    end else if (hold_drain) begin
      hold_full <= 1'b0;
    end
  end

endmodule

// File: tb/tb_word_serializer.sv
// Scoreboard bench: stimulus pushes expected serial bits, monitors pop and compare.
module tb_word_serializer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_data, in_data_l;
  logic       in_valid, in_valid_l;
  logic       in_ready, ser_out, ser_valid, frame_start, last_bit;
  logic       in_ready_l, ser_out_l, ser_valid_l, frame_start_l, last_bit_l;

  int tests = 0;
  int fails = 0;
  int vcnt  = 0;

  // {bit, frame_start, last_bit}
  logic [2:0] q[$];
  logic [2:0] ql[$];

  always #5 clk = ~clk;

  word_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .ser_out(ser_out), .ser_valid(ser_valid),
    .frame_start(frame_start), .last_bit(last_bit));

  word_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .reset(reset), .in_data(in_data_l), .in_valid(in_valid_l),
    .in_ready(in_ready_l), .ser_out(ser_out_l), .ser_valid(ser_valid_l),
    .frame_start(frame_start_l), .last_bit(last_bit_l));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // stream[7] is the first bit on the wire
  task automatic push_exp(input logic [7:0] stream, input bit lsb_dut);
    for (int i = 7; i >= 0; i--) begin
      if (lsb_dut) ql.push_back({stream[i], i == 7, i == 0});
      else         q.push_back({stream[i], i == 7, i == 0});
    end
  endtask

  // Call at posedge+1; returns at posedge+1 after the transfer edge.
  task automatic send(input logic [7:0] w, input logic [7:0] stream);
    logic r;
    int   n;
    in_data  = w;
    in_valid = 1'b1;
    n = 0;
    forever begin
      r = in_ready;
      @(posedge clk); #1;
      if (r) break;
      n++;
      if (n > 50) begin
        chk("send_timeout", 0, 1);
        break;
      end
    end
    in_valid = 1'b0;
    in_data  = 8'h00;
    if (r) begin
      push_exp(stream, 1'b0);
      chk("first_bit_latency", ser_valid, 1);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (ser_valid) begin
        vcnt++;
        if (q.size() == 0) chk("unexpected_bit", 1, 0);
        else chk("msb_stream", {ser_out, frame_start, last_bit}, q.pop_front());
      end else begin
        if (q.size() != 0) chk("valid_gap", ser_valid, 1);
        if (ser_out || frame_start || last_bit)
          chk("idle_outputs", {ser_out, frame_start, last_bit}, 0);
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (ser_valid_l) begin
        if (ql.size() == 0) chk("unexpected_bit_l", 1, 0);
        else chk("lsb_stream", {ser_out_l, frame_start_l, last_bit_l}, ql.pop_front());
      end else if (ql.size() != 0) begin
        chk("valid_gap_l", ser_valid_l, 1);
      end
    end
  end

  initial begin
    int v0, n;
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_valid_l = 1'b0; in_data_l = '0;
    #12;
    chk("reset_in_ready", in_ready, 0);
    chk("reset_outputs", {ser_out, ser_valid, frame_start, last_bit}, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("post_reset_in_ready", in_ready, 1);
    cycles(2);

    // single word, MSB first
    v0 = vcnt;
    send(8'hB0, 8'b1011_0000);
    cycles(12);
    chk("b0_valid_cycles", vcnt - v0, 8);

    // back-to-back: second word lands in hold
    v0 = vcnt;
    send(8'hA5, 8'b1010_0101);
    send(8'h3C, 8'b0011_1100);
    chk("hold_in_ready_low", in_ready, 0);
    cycles(6);
    chk("hold_still_full", in_ready, 0);
    cycles(1);
    chk("hold_drained_ready", in_ready, 1);
    cycles(14);
    chk("b2b_valid_cycles", vcnt - v0, 16);

    // same-edge reload on the last-bit cycle
    v0 = vcnt;
    send(8'h11, 8'b0001_0001);
    n = 0;
    while (!last_bit && n < 20) begin
      cycles(1);
      n++;
    end
    chk("last_bit_seen", last_bit, 1);
    send(8'h96, 8'b1001_0110);
    chk("reload_frame_start", frame_start, 1);
    chk("reload_hold_empty", in_ready, 1);
    cycles(12);
    chk("reload_valid_cycles", vcnt - v0, 16);

    // LSB-first instance
    in_data_l  = 8'h0D;
    in_valid_l = 1'b1;
    chk("lsb_in_ready", in_ready_l, 1);
    @(posedge clk); #1;
    in_valid_l = 1'b0;
    push_exp(8'b1011_0000, 1'b1);
    chk("lsb_latency", ser_valid_l, 1);
    cycles(12);
    chk("lsb_drained", ql.size(), 0);

    // reset mid-frame with a word held
    send(8'hF0, 8'b1111_0000);
    send(8'hFF, 8'b1111_1111);
    cycles(2);
    chk("pre_reset_bit3", {ser_out, ser_valid, in_ready}, 3'b110);
    reset = 1'b1;
    #1;
    chk("async_clear", {ser_out, ser_valid, frame_start, last_bit, in_ready}, 0);
    q.delete();
    cycles(2);
    reset = 1'b0;
    #1;
    chk("rst_release_ready", in_ready, 1);
    chk("rst_release_valid", ser_valid, 0);
    v0 = vcnt;
    cycles(12);
    chk("no_stale_bits", vcnt - v0, 0);

    // idle
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle", {ser_out, ser_valid, in_ready}, 3'b001);
    end

    chk("scoreboard_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
